// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: FSM state encoding, rate-code constants and config-bus default width for tick_sched
package tick_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, SWITCH} state_t;
  localparam logic [1:0] RATE_0 = 2'd0;
  localparam logic [1:0] RATE_1 = 2'd1;
  localparam logic [1:0] RATE_2 = 2'd2;
  localparam logic [1:0] RATE_3 = 2'd3;
  localparam int NB_SW_DEF = 3;
endpackage

// File: rtl/tick_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req = request vector, start = first index searched,
// grant = one-hot winner (zero when no request), idx = winner index
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);
  logic [IW-1:0] j;
  logic          hit;
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = '0;
    hit   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = IW'((int'(start) + i) % N_REQ);
      if (!hit && req[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
    grant[idx] = hit;
  end
endmodule

// File: rtl/tick_sched.sv
// tick_sched: grants one requester at a time a quantum of rate-counter ticks, round-robin.
// Ports: clock; i_reset_n (sync, active-low); i_req level requests; i_rate 2-bit rate per requester;
// i_tick counter pulse; o_sw counter config {rate, enable}; o_cnt_clr counter clear; o_grant one-hot owner;
// o_tick forwarded tick; o_busy not idle; o_drop_cnt saturating dropped-tick count (TICK_SCHED_STATS_EN only).
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NB_SW   = NB_SW_DEF,
  parameter int N_REQ   = 4,
  parameter int QUANTUM = 8
) (
  input  logic               clock,
  input  logic               i_reset_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [2*N_REQ-1:0] i_rate,
  input  logic               i_tick,
  output logic [NB_SW-1:0]   o_sw,
  output logic               o_cnt_clr,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_tick,
  output logic               o_busy
`ifdef TICK_SCHED_STATS_EN
  ,
  output logic [15:0]        o_drop_cnt
`endif
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(QUANTUM + 1);
  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win;
  logic [1:0]       rate;
  logic [1:0]       win_rate;
  logic             en;
  logic             own_req;
  logic [CW-1:0]    cnt;
  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req   (i_req),
    .start (ptr),
    .grant (win),
    .idx   (win_idx)
  );
  // o_grant is one-hot in RUN, so this is the owner's own request bit
  assign own_req = |(i_req & o_grant);
  assign o_sw    = NB_SW'({rate, en});
  always_comb begin
    win_rate = RATE_0;
    for (int k = 0; k < N_REQ; k++) win_rate = win[k] ? i_rate[2*k +: 2] : win_rate;
  end
  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      rate      <= RATE_0;
      en        <= 1'b0;
      o_cnt_clr <= 1'b1;
      o_grant   <= '0;
      o_tick    <= '0;
      o_busy    <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      o_tick <= '0;
      case (state)
        // SWITCH re-arbitrates exactly like IDLE; a sole requester is simply granted again
        IDLE, SWITCH: begin
          state     <= |i_req ? LOAD : IDLE;
          o_grant   <= win;
          rate      <= |i_req ? win_rate : RATE_0;
          en        <= 1'b0;
          o_cnt_clr <= 1'b1;
          o_busy    <= |i_req;
          cnt       <= '0;
          if (|i_req) ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
        LOAD: begin
          state     <= RUN;
          en        <= 1'b1;
          o_cnt_clr <= 1'b0;
        end
        RUN: begin
          if (!own_req || (i_tick && cnt == CW'(QUANTUM - 1))) begin
            state   <= SWITCH;
            en      <= 1'b0;
            o_grant <= '0;
          end
          if (own_req && i_tick) begin
            o_tick <= o_grant;
            cnt    <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TICK_SCHED_STATS_EN
  // every tick not forwarded to a live owner in RUN counts as dropped
  always_ff @(posedge clock) begin
    if (!i_reset_n) o_drop_cnt <= '0;
    else if (i_tick && !(state == RUN && own_req) && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed scenarios for tick_sched with a forwarded-tick scoreboard
module tb_tick_sched;
  import tick_sched_pkg::*;
  localparam int N = 4;
  typedef struct {
    int           due;
    logic [N-1:0] val;
  } exp_t;
  logic           clock = 1'b0;
  logic           i_reset_n;
  logic           i_tick;
  logic [N-1:0]   i_req;
  logic [2*N-1:0] i_rate;
  logic [2:0]     o_sw;
  logic           o_cnt_clr;
  logic           o_busy;
  logic [N-1:0]   o_grant;
  logic [N-1:0]   o_tick;
`ifdef TICK_SCHED_STATS_EN
  logic [15:0]    o_drop_cnt;
  int             exp_drop = 0;
`endif
  exp_t           sb[$];
  exp_t           mon_x;
  logic [N-1:0]   mon_exp;
  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  int             rr_own[4] = '{0, 1, 3, 0};
  int             rr_rate[4] = '{0, 1, 0, 3};

  tick_sched #(.NB_SW(3), .N_REQ(N), .QUANTUM(8)) dut (
    .clock      (clock),
    .i_reset_n  (i_reset_n),
    .i_req      (i_req),
    .i_rate     (i_rate),
    .i_tick     (i_tick),
    .o_sw       (o_sw),
    .o_cnt_clr  (o_cnt_clr),
    .o_grant    (o_grant),
    .o_tick     (o_tick),
    .o_busy     (o_busy)
`ifdef TICK_SCHED_STATS_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // each tick driven while the owner holds its request must reappear on o_tick one edge later
  task automatic send_ticks(input int n, input int own);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      i_tick = 1'b1;
      x.due = cyc + 1;
      x.val = N'(1) << own;
      sb.push_back(x);
      step();
      i_tick = 1'b0;
      if (i < n - 1) step();
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    #2;
    mon_exp = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_x   = sb.pop_front();
      mon_exp = mon_x.val;
    end
    total++;
    assert (o_tick === mon_exp) else begin
      bad++;
      $error("FAIL o_tick cycle=%0d observed=%b expected=%b", cyc, o_tick, mon_exp);
    end
  end

  initial begin
    i_reset_n = 1'b0;
    i_req     = '0;
    i_rate    = '0;
    i_tick    = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_sw", 32'(o_sw), 0);
    chk("rst_clr", 32'(o_cnt_clr), 1);
    chk("rst_busy", 32'(o_busy), 0);
`ifdef TICK_SCHED_STATS_EN
    chk("rst_drop", 32'(o_drop_cnt), 0);
`endif
    i_reset_n = 1'b1;
    step();
    chk("idle_grant", 32'(o_grant), 0);
    // single requester, rate 2
    i_req  = 4'b0001;
    i_rate = {RATE_0, RATE_0, RATE_0, RATE_2};
    step();
    chk("s1_ld_grant", 32'(o_grant), 1);
    chk("s1_ld_sw", 32'(o_sw), 3'b100);
    chk("s1_ld_clr", 32'(o_cnt_clr), 1);
    chk("s1_ld_busy", 32'(o_busy), 1);
    step();
    chk("s1_run_sw", 32'(o_sw), 3'b101);
    chk("s1_run_clr", 32'(o_cnt_clr), 0);
    send_ticks(8, 0);
    chk("s1_swt_grant", 32'(o_grant), 0);
    chk("s1_swt_en", 32'(o_sw[0]), 0);
    chk("s1_swt_busy", 32'(o_busy), 1);
    step();
    chk("s1_regrant", 32'(o_grant), 1);
    chk("s1_reclr", 32'(o_cnt_clr), 1);
    i_req = '0;
    step();
    step();
    step();
    chk("s1_idle_busy", 32'(o_busy), 0);
    chk("s1_idle_sw", 32'(o_sw), 0);
    // round-robin over 1011 starting from a fresh reset
    i_reset_n = 1'b0;
    step();
    i_reset_n = 1'b1;
    i_req  = 4'b1011;
    i_rate = {RATE_3, RATE_0, RATE_1, RATE_0};
    for (int g = 0; g < 4; g++) begin
      step();
      chk("rr_ld_grant", 32'(o_grant), 32'(1) << rr_own[g]);
      chk("rr_ld_sw", 32'(o_sw), rr_rate[rr_own[g]] * 2);
      chk("rr_ld_clr", 32'(o_cnt_clr), 1);
      step();
      chk("rr_run_sw", 32'(o_sw), rr_rate[rr_own[g]] * 2 + 1);
      send_ticks(8, rr_own[g]);
      chk("rr_swt_grant", 32'(o_grant), 0);
    end
    // early release by requester 1 with a tick in the release cycle
    i_req = 4'b0010;
    step();
    chk("er_ld_grant", 32'(o_grant), 2);
    step();
    send_ticks(3, 1);
    i_req  = '0;
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    chk("er_swt_grant", 32'(o_grant), 0);
    chk("er_swt_busy", 32'(o_busy), 1);
`ifdef TICK_SCHED_STATS_EN
    exp_drop++;
    chk("er_drop", 32'(o_drop_cnt), exp_drop);
`endif
    step();
    chk("er_idle_busy", 32'(o_busy), 0);
    // rate freeze: new rate only takes effect at the next LOAD
    i_req  = 4'b0100;
    i_rate = {RATE_0, RATE_1, RATE_0, RATE_0};
    step();
    chk("rf_ld_grant", 32'(o_grant), 4);
    chk("rf_ld_sw", 32'(o_sw), 3'b010);
    step();
    chk("rf_run_sw", 32'(o_sw), 3'b011);
    i_rate = {RATE_0, RATE_3, RATE_0, RATE_0};
    send_ticks(2, 2);
    chk("rf_hold_sw", 32'(o_sw), 3'b011);
    step();
    send_ticks(6, 2);
    chk("rf_swt_sw", 32'(o_sw), 3'b010);
    step();
    chk("rf_reld_sw", 32'(o_sw), 3'b110);
    chk("rf_reld_grant", 32'(o_grant), 4);
    step();
    // reset mid-RUN after two ticks
    send_ticks(2, 2);
    i_reset_n = 1'b0;
    i_tick    = 1'b1;
    step();
    chk("mr_grant", 32'(o_grant), 0);
    chk("mr_sw", 32'(o_sw), 0);
    chk("mr_clr", 32'(o_cnt_clr), 1);
    chk("mr_busy", 32'(o_busy), 0);
`ifdef TICK_SCHED_STATS_EN
    exp_drop = 0;
    chk("mr_drop", 32'(o_drop_cnt), exp_drop);
`endif
    i_reset_n = 1'b1;
    i_tick    = 1'b0;
    i_req     = 4'b0101;
    step();
    chk("mr_first_grant", 32'(o_grant), 1);
    i_req = '0;
    step();
    step();
    step();
    chk("mr_idle_busy", 32'(o_busy), 0);
    // stray ticks while idle
    for (int s = 0; s < 5; s++) begin
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
      step();
    end
    chk("st_grant", 32'(o_grant), 0);
    chk("st_busy", 32'(o_busy), 0);
`ifdef TICK_SCHED_STATS_EN
    exp_drop += 5;
    chk("st_drop", 32'(o_drop_cnt), exp_drop);
    i_tick = 1'b1;
    repeat (65532) step();
    i_tick = 1'b0;
    exp_drop = 65535;
    chk("st_sat", 32'(o_drop_cnt), exp_drop);
    i_tick = 1'b1;
    step();
    step();
    i_tick = 1'b0;
    chk("st_sat_hold", 32'(o_drop_cnt), exp_drop);
`endif
    step();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
